// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC front-end and resynthesis stages.
package mfcc_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned ACC_W     = 18;
    localparam int unsigned MAX_FRAME = 256;
    localparam int unsigned ADDR_W    = $clog2(MAX_FRAME);
    localparam int unsigned CFG_W     = 8;

    localparam logic [DATA_W-1:0] Q15_MAX = DATA_W'(16'h7FFF);
    localparam logic [DATA_W-1:0] Q15_MIN = DATA_W'(16'h8000);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } oad_state_e;

endpackage

// File: rtl/overlap_add_deframer_if.sv
// Valid/ready sample stream used for both the frame input and the sample output.
interface overlap_add_deframer_if;

    logic [mfcc_pkg::DATA_W-1:0] data;
    logic                        valid;
    logic                        ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);

endinterface

// File: rtl/sat_q15.sv
// Saturating narrower from an ACC_W signed accumulator value to Q1.15.
module sat_q15
    import mfcc_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    output logic [DATA_W-1:0] sat_c
);

    // Bits above the Q1.15 sign must all match the sign, otherwise clamp.
    logic [ACC_W-DATA_W:0] top;
    assign top = acc[ACC_W-1:DATA_W-1];

    always_comb begin
        sat_c = acc[DATA_W-1:0];
        if (!(&top) && (|top)) begin
            sat_c = acc[ACC_W-1] ? Q15_MIN : Q15_MAX;
        end
    end

endmodule

// File: rtl/overlap_add_deframer.sv
// Overlap-add reconstruction of a continuous Q1.15 stream from windowed frames,
// using a circular accumulator that is cleared as each finished sample leaves.
module overlap_add_deframer
    import mfcc_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CFG_W-1:0]              frame_size,
    input  logic [CFG_W-1:0]              frame_overlap,
    input  logic                          flush,
    overlap_add_deframer_if.slave         in_if,
    overlap_add_deframer_if.master        out_if,
    output logic                          cfg_err,
    output logic                          flush_done
);

    oad_state_e state_q, state_d;

    logic [ADDR_W-1:0] base_q, clr_q;
    logic [CFG_W-1:0]  idx_q, j_q, fs_q, hop_q;
    logic              latched_q, flush_pend_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    logic [ACC_W-1:0]  acc_mem [MAX_FRAME];
    logic [ADDR_W-1:0] acc_addr;
    logic [ACC_W-1:0]  rd_data, acc_wdata, in_ext;
    logic              acc_we;
    logic [DATA_W-1:0] sat_data;

    logic cfg_bad, at_bound, go_flush, in_ready, in_fire, last_in;
    logic emitting, out_free, load, seg_done;
    logic [CFG_W-1:0] lim;

    // Frame-boundary decisions; config and flush only matter at idx==0.
    assign cfg_bad  = (frame_size < CFG_W'(2)) || (frame_overlap >= frame_size);
    assign at_bound = (state_q == ST_ACCUM) && (idx_q == '0);
    assign go_flush = at_bound && (flush_pend_q || flush);
    assign in_ready = !rst && (state_q == ST_ACCUM) && !go_flush && !(at_bound && cfg_bad);
    assign in_fire  = in_ready && in_if.valid;
    assign last_in  = in_fire && (idx_q != '0) && (idx_q == fs_q - CFG_W'(1));

    assign in_if.ready  = in_ready;
    assign out_if.data  = out_data_q;
    assign out_if.valid = out_valid_q;

    // DRAIN emits hop samples; FLUSH emits the overlap tail of the last latched frame.
    assign emitting = (state_q == ST_DRAIN) || (state_q == ST_FLUSH);
    assign lim      = (state_q == ST_DRAIN) ? hop_q :
                      (latched_q ? (fs_q - hop_q) : CFG_W'(0));
    assign out_free = !out_valid_q || out_if.ready;
    assign load     = emitting && (j_q != lim) && out_free;
    assign seg_done = emitting && (j_q == lim) && out_free;

    assign in_ext = {{(ACC_W-DATA_W){in_if.data[DATA_W-1]}}, in_if.data};

    always_comb begin
        acc_addr = base_q + ADDR_W'(j_q);
        case (state_q)
            ST_CLEAR: acc_addr = clr_q;
            ST_ACCUM: acc_addr = base_q + ADDR_W'(idx_q);
            default:  acc_addr = base_q + ADDR_W'(j_q);
        endcase
    end

    assign rd_data = acc_mem[acc_addr];

    sat_q15 u_sat (
        .acc   (rd_data),
        .sat_c (sat_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_CLEAR;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        acc_we    = 1'b0;
        acc_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                acc_we = 1'b1;
                if (clr_q == ADDR_W'(MAX_FRAME - 1)) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                acc_we    = in_fire;
                acc_wdata = rd_data + in_ext;
                if (go_flush)     state_d = ST_FLUSH;
                else if (last_in) state_d = ST_DRAIN;
            end
            ST_DRAIN, ST_FLUSH: begin
                acc_we = load;
                if (seg_done) state_d = ST_ACCUM;
            end
            default: state_d = ST_CLEAR;
        endcase
        if (rst) acc_we = 1'b0;
    end

    // Single read-modify-write port, no reset, so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (acc_we) acc_mem[acc_addr] <= acc_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            clr_q        <= '0;
            idx_q        <= '0;
            j_q          <= '0;
            fs_q         <= '0;
            hop_q        <= '0;
            latched_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            cfg_err      <= 1'b0;
            flush_done   <= 1'b0;
        end else begin
            flush_done <= 1'b0;

            if (state_q == ST_CLEAR) begin
                clr_q <= clr_q + ADDR_W'(1);
                if (state_d == ST_ACCUM) begin
                    base_q <= '0;
                    idx_q  <= '0;
                end
            end

            if (go_flush)
                flush_pend_q <= 1'b0;
            else if (flush && state_q != ST_CLEAR)
                flush_pend_q <= 1'b1;

            if (at_bound) cfg_err <= cfg_bad;

            if (in_fire) begin
                if (idx_q == '0) begin
                    fs_q      <= frame_size;
                    hop_q     <= frame_size - frame_overlap;
                    latched_q <= 1'b1;
                end
                if (last_in) begin
                    idx_q <= '0;
                    j_q   <= '0;
                end else begin
                    idx_q <= idx_q + CFG_W'(1);
                end
            end

            if (go_flush) j_q <= '0;

            if (load) begin
                out_data_q  <= sat_data;
                out_valid_q <= 1'b1;
                j_q         <= j_q + CFG_W'(1);
            end else if (out_if.ready) begin
                out_valid_q <= 1'b0;
            end

            if (seg_done) begin
                j_q <= '0;
                if (state_q == ST_DRAIN) begin
                    base_q <= base_q + ADDR_W'(hop_q);
                end else begin
                    base_q     <= '0;
                    latched_q  <= 1'b0;
                    flush_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_overlap_add_deframer.sv
// Self-checking bench: randomized frames against an absolute-position overlap-add model.
module tb_overlap_add_deframer;
    import mfcc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] frame_size, frame_overlap;
    logic       flush;
    logic       cfg_err, flush_done;
    logic       force_lo, rnd_rdy;

    overlap_add_deframer_if in_if();
    overlap_add_deframer_if out_if();

    overlap_add_deframer dut (
        .clk           (clk),
        .rst           (rst),
        .frame_size    (frame_size),
        .frame_overlap (frame_overlap),
        .flush         (flush),
        .in_if         (in_if),
        .out_if        (out_if),
        .cfg_err       (cfg_err),
        .flush_done    (flush_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: the reconstructed signal y[] at absolute sample positions.
    int          y[int];
    int          pos = 0;
    int          cur_ovl = 0;
    bit          have = 0;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    logic [15:0] frame_buf[$];

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction

    function automatic int yget(input int k);
        return y.exists(k) ? y[k] : 0;
    endfunction

    task automatic model_frame(input int fs, input int ovl);
        for (int i = 0; i < fs; i++) y[pos + i] = yget(pos + i) + int'($signed(frame_buf[i]));
        for (int k = 0; k < fs - ovl; k++) exp_q.push_back(sat16(yget(pos + k)));
        pos += fs - ovl;
        cur_ovl = ovl;
        have = 1;
    endtask

    task automatic model_flush();
        if (have) for (int k = 0; k < cur_ovl; k++) exp_q.push_back(sat16(yget(pos + k)));
        y.delete();
        pos = 0;
        have = 0;
    endtask

    task automatic model_reset();
        y.delete();
        pos = 0;
        have = 0;
        exp_q.delete();
    endtask

    // Output monitor and flush_done counter, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!rst && out_if.valid && out_if.ready) begin
            got_q.push_back(out_if.data);
            if (exp_q.size() == 0) chk("extra_out", 32'(out_if.data), 32'hDEAD_0000);
            else                   chk("out_data", 32'(out_if.data), 32'(exp_q.pop_front()));
        end
        if (!rst && flush_done) fd_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_if.ready = force_lo ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send_sample(input logic [15:0] d, input bit gap);
        bit acc = 0;
        if (gap && $urandom_range(0, 3) == 0) begin
            in_if.valid = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        end
        in_if.valid = 1'b1;
        in_if.data  = d;
        for (int c = 0; c < 3000 && !acc; c++) begin
            @(negedge clk);
            acc = in_if.ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("in_timeout", 0, 1);
        in_if.valid = 1'b0;
    endtask

    task automatic send_frame(input int fs, input int ovl, input bit gap);
        frame_size    = 8'(fs);
        frame_overlap = 8'(ovl);
        model_frame(fs, ovl);
        for (int i = 0; i < fs; i++) send_sample(frame_buf[i], gap);
    endtask

    task automatic fill(input int n, input logic [15:0] v);
        frame_buf.delete();
        for (int i = 0; i < n; i++) frame_buf.push_back(v);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin @(posedge clk); #1; end
        chk("drain_left", exp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic wait_clear();
        int lows = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (in_if.ready) break;
            lows++;
        end
        chk("clear_len", lows, 256);
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input bit collide);
        int fd0 = fd_cnt;
        model_flush();
        flush = 1'b1;
        if (collide) begin
            in_if.valid = 1'b1;
            in_if.data  = 16'h5555;
        end
        @(negedge clk);
        if (collide) chk("collide_ready", 32'(in_if.ready), 0);
        @(posedge clk);
        #1;
        flush       = 1'b0;
        in_if.valid = 1'b0;
        for (int c = 0; c < 3000 && fd_cnt == fd0; c++) begin @(posedge clk); #1; end
        chk("flush_done_cnt", fd_cnt - fd0, 1);
        @(negedge clk);
        chk("flush_done_pulse", 32'(flush_done), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; force_lo = 1'b0; rnd_rdy = 1'b0;
        in_if.valid = 1'b0; in_if.data = '0; out_if.ready = 1'b1;
        frame_size = 8'd4; frame_overlap = 8'd2;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_if.ready), 0);
        chk("rst_out_valid", 32'(out_if.valid), 0);
        chk("rst_out_data", 32'(out_if.data), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_flush_done", 32'(flush_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear();

        // fs=4 overlap=2 constant 0x1000
        got_q.delete();
        fill(4, 16'h1000);
        send_frame(4, 2, 0);
        send_frame(4, 2, 0);
        do_flush(0);
        wait_drain();
        chk("ola_f1_0", 32'(got_q[0]), 32'h1000);
        chk("ola_f1_1", 32'(got_q[1]), 32'h1000);
        chk("ola_f2_0", 32'(got_q[2]), 32'h2000);
        chk("ola_f2_1", 32'(got_q[3]), 32'h2000);
        chk("ola_tail0", 32'(got_q[4]), 32'h1000);
        chk("ola_tail1", 32'(got_q[5]), 32'h1000);
        chk("ola_count", got_q.size(), 6);

        // Saturation both ways
        got_q.delete();
        fill(4, 16'h7000);
        send_frame(4, 3, 0);
        send_frame(4, 3, 0);
        do_flush(0);
        wait_drain();
        chk("sat_pos", 32'(got_q[1]), 32'h7FFF);
        got_q.delete();
        fill(4, 16'h9000);
        send_frame(4, 3, 0);
        send_frame(4, 3, 0);
        do_flush(0);
        wait_drain();
        chk("sat_neg", 32'(got_q[1]), 32'h8000);

        // Backpressure mid-DRAIN
        got_q.delete();
        force_lo = 1'b1;
        frame_buf.delete();
        for (int i = 0; i < 8; i++) frame_buf.push_back(16'(16'h0100 * (i + 1)));
        send_frame(8, 0, 0);
        @(posedge clk);
        #1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_if.ready), 0);
            chk("bp_valid", 32'(out_if.valid), 1);
            chk("bp_hold", 32'(out_if.data), 32'h0100);
            @(posedge clk);
            #1;
        end
        force_lo = 1'b0;
        wait_drain();
        chk("bp_count", got_q.size(), 8);
        do_flush(0);

        // Illegal config, then legal
        frame_size = 8'd4; frame_overlap = 8'd4;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("cfg_err_set", 32'(cfg_err), 1);
        chk("cfg_in_ready", 32'(in_if.ready), 0);
        @(posedge clk);
        #1;
        frame_overlap = 8'd1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("cfg_err_clr", 32'(cfg_err), 0);
        @(posedge clk);
        #1;
        got_q.delete();
        fill(4, 16'h0400);
        send_frame(4, 1, 0);
        send_frame(4, 1, 0);
        wait_drain();
        chk("cfg_hop3", got_q.size(), 6);
        do_flush(0);
        do_flush(0);

        // Flush colliding with a sample at the frame boundary
        fill(6, 16'h0800);
        send_frame(6, 2, 0);
        send_frame(6, 2, 0);
        wait_drain();
        do_flush(1);
        got_q.delete();
        fill(4, 16'h0123);
        send_frame(4, 0, 0);
        wait_drain();
        chk("post_flush0", 32'(got_q[0]), 32'h0123);
        chk("post_flush3", 32'(got_q[3]), 32'h0123);
        do_flush(0);

        // Randomized streams with input gaps and output backpressure
        rnd_rdy = 1'b1;
        for (int s = 0; s < 6; s++) begin
            int fs, ovl, nf;
            fs  = $urandom_range(2, 40);
            ovl = $urandom_range(0, fs - (fs + 3) / 4);
            nf  = $urandom_range(1, 5);
            for (int f = 0; f < nf; f++) begin
                frame_buf.delete();
                for (int i = 0; i < fs; i++) frame_buf.push_back(16'($urandom));
                send_frame(fs, ovl, 1);
            end
            do_flush(0);
        end
        wait_drain();
        rnd_rdy = 1'b0;

        // Reset while DRAIN is stalled
        force_lo = 1'b1;
        fill(8, 16'h0200);
        send_frame(8, 0, 0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drain_valid", 32'(out_if.valid), 0);
        chk("rst_drain_ready", 32'(in_if.ready), 0);
        model_reset();
        rst = 1'b0;
        force_lo = 1'b0;
        wait_clear();
        repeat (4) begin @(posedge clk); #1; end
        chk("final_queue", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
